// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register-file writeback arbiter with busy scoreboard
// Optional WB_BYPASS_EN: a committing write clears its busy bit for the same-cycle stall check.
module regfile_wb_scheduler #(
    parameter int index_width = 3,
    parameter int reg_width   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iss_valid,
    input  logic                          iss_rd_we,
    input  logic [index_width-1:0]        iss_rd,
    input  logic [index_width-1:0]        iss_rs1,
    input  logic [index_width-1:0]        iss_rs2,
    output logic                          iss_stall,
    input  logic                          alu_valid,
    input  logic [index_width-1:0]        alu_rd,
    input  logic [reg_width-1:0]          alu_data,
    output logic                          alu_ready,
    input  logic                          lsu_valid,
    input  logic [index_width-1:0]        lsu_rd,
    input  logic [reg_width-1:0]          lsu_data,
    output logic                          lsu_ready,
    output logic                          rf_we,
    output logic [index_width-1:0]        rf_waddr,
    output logic [reg_width-1:0]          rf_wdata,
    output logic [(1<<index_width)-1:0]   busy,
    output logic                          wb_err
);
    localparam int num_regs = 1 << index_width;

    // 1 = LSU was granted last, so ALU takes the next contention
    logic                   last_grant;
    logic                   alu_grant;
    logic                   lsu_grant;
    logic                   wb_fire;
    logic [index_width-1:0] wb_rd;
    logic [reg_width-1:0]   wb_data;
    logic                   iss_accept;
    logic [num_regs-1:0]    stall_busy;
    logic [num_regs-1:0]    busy_next;

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                alu_grant = last_grant;
                lsu_grant = !last_grant;
            end else begin
                alu_grant = alu_valid;
                lsu_grant = lsu_valid;
            end
        end
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;
    assign wb_fire   = alu_grant || lsu_grant;
    assign wb_rd     = alu_grant ? alu_rd : lsu_rd;
    assign wb_data   = alu_grant ? alu_data : lsu_data;

    always_comb begin
        stall_busy = busy;
`ifdef WB_BYPASS_EN
        if (rf_we) begin
            stall_busy[rf_waddr] = 1'b0;
        end
`endif
    end

    assign iss_stall  = iss_valid && (stall_busy[iss_rs1] || stall_busy[iss_rs2] ||
                                      (iss_rd_we && stall_busy[iss_rd]));
    assign iss_accept = iss_valid && !iss_stall;

    // Set is applied after clear so a same-index issue keeps the register busy
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (iss_accept && iss_rd_we) begin
            busy_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            wb_err     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            busy  <= busy_next;
            rf_we <= wb_fire;
            if (wb_fire) begin
                rf_waddr   <= wb_rd;
                rf_wdata   <= wb_data;
                last_grant <= lsu_grant;
                if (!busy[wb_rd]) begin
                    wb_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed vector table plus randomized model check
module tb_regfile_wb_scheduler;
    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic        iss_rd_we;
    logic [2:0]  iss_rd;
    logic [2:0]  iss_rs1;
    logic [2:0]  iss_rs2;
    logic        iss_stall;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [2:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  busy;
    logic        wb_err;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_wb_scheduler #(.index_width(3), .reg_width(32)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd_we(iss_rd_we), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, iv, iwe;
        logic [2:0]  ird, irs1, irs2;
        logic        av;
        logic [2:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [2:0]  lrd;
        logic [31:0] ldata;
        logic        e_stall, e_ar, e_lr, e_we;
        logic [2:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [7:0]  e_busy;
        logic        e_err;
    } vec_t;

    function automatic vec_t v(
        input logic r, input logic iv, input logic iwe,
        input logic [2:0] ird, input logic [2:0] irs1, input logic [2:0] irs2,
        input logic av, input logic [2:0] ard, input logic [31:0] ad,
        input logic lv, input logic [2:0] lrd, input logic [31:0] ld,
        input logic es, input logic ear, input logic elr, input logic ewe,
        input logic [2:0] ewa, input logic [31:0] ewd, input logic [7:0] eb, input logic eerr);
        vec_t t;
        t.rst = r; t.iv = iv; t.iwe = iwe; t.ird = ird; t.irs1 = irs1; t.irs2 = irs2;
        t.av = av; t.ard = ard; t.adata = ad; t.lv = lv; t.lrd = lrd; t.ldata = ld;
        t.e_stall = es; t.e_ar = ear; t.e_lr = elr; t.e_we = ewe;
        t.e_waddr = ewa; t.e_wdata = ewd; t.e_busy = eb; t.e_err = eerr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; iss_valid = t.iv; iss_rd_we = t.iwe;
        iss_rd = t.ird; iss_rs1 = t.irs1; iss_rs2 = t.irs2;
        alu_valid = t.av; alu_rd = t.ard; alu_data = t.adata;
        lsu_valid = t.lv; lsu_rd = t.lrd; lsu_data = t.ldata;
    endtask

    vec_t vecs[23];

    // reference model state
    bit          m_busy[8];
    bit          m_alu_pri;
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;

    initial begin
        logic byp_stall;
`ifdef WB_BYPASS_EN
        byp_stall = 1'b0;
`else
        byp_stall = 1'b1;
`endif
        //            rst iv iwe rd rs1 rs2 av ard adata        lv lrd ldata     stall ar lr we wa wdata         busy   err
        vecs[0]  = v(1, 0, 0, 0, 0, 0, 1, 0, 32'h0,        1, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        8'h00, 0);
        vecs[1]  = v(0, 1, 1, 3, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        8'h00, 0);
        vecs[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        8'h08, 0);
        vecs[3]  = v(0, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 32'h0,   0, 1, 0, 0, 0, 32'h0,        8'h08, 0);
        vecs[4]  = v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 1, 3, 32'hDEADBEEF, 8'h08, 0);
        vecs[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 3, 32'hDEADBEEF, 8'h00, 0);
        vecs[6]  = v(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 3, 32'hDEADBEEF, 8'h00, 0);
        vecs[7]  = v(0, 0, 0, 0, 0, 0, 1, 0, 32'hA0,       1, 1, 32'hB1,  0, 1, 0, 0, 0, 32'h0,        8'h00, 0);
        vecs[8]  = v(0, 0, 0, 0, 0, 0, 1, 2, 32'hA2,       1, 3, 32'hB3,  0, 0, 1, 1, 0, 32'hA0,       8'h00, 1);
        vecs[9]  = v(0, 0, 0, 0, 0, 0, 1, 4, 32'hA4,       1, 5, 32'hB5,  0, 1, 0, 1, 3, 32'hB3,       8'h00, 1);
        vecs[10] = v(0, 0, 0, 0, 0, 0, 1, 6, 32'hA6,       1, 7, 32'hB7,  0, 0, 1, 1, 4, 32'hA4,       8'h00, 1);
        vecs[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 1, 7, 32'hB7,       8'h00, 1);
        vecs[12] = v(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 7, 32'hB7,       8'h00, 1);
        vecs[13] = v(0, 1, 1, 2, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        8'h00, 0);
        vecs[14] = v(0, 1, 0, 0, 2, 0, 1, 2, 32'hC2,       0, 0, 32'h0,   1, 1, 0, 0, 0, 32'h0,        8'h04, 0);
        vecs[15] = v(0, 1, 0, 0, 2, 0, 0, 0, 32'h0,        0, 0, 32'h0,   byp_stall, 0, 0, 1, 2, 32'hC2, 8'h04, 0);
        vecs[16] = v(0, 1, 0, 0, 2, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 2, 32'hC2,       8'h00, 0);
        vecs[17] = v(0, 0, 0, 0, 0, 0, 1, 5, 32'hD5,       0, 0, 32'h0,   0, 1, 0, 0, 2, 32'hC2,       8'h00, 0);
        vecs[18] = v(0, 1, 1, 5, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 1, 5, 32'hD5,       8'h00, 1);
        vecs[19] = v(0, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,   1, 0, 0, 0, 5, 32'hD5,       8'h20, 1);
        vecs[20] = v(0, 0, 0, 0, 0, 0, 1, 5, 32'hE5,       0, 0, 32'h0,   0, 1, 0, 0, 5, 32'hD5,       8'h20, 1);
        vecs[21] = v(1, 0, 0, 0, 0, 0, 1, 5, 32'hF5,       0, 0, 32'h0,   0, 0, 0, 1, 5, 32'hE5,       8'h20, 1);
        vecs[22] = v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        8'h00, 0);

        drive(vecs[22]);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("row%0d iss_stall", i), 32'(iss_stall), 32'(vecs[i].e_stall));
            chk($sformatf("row%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            chk($sformatf("row%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lr));
            chk($sformatf("row%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            chk($sformatf("row%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
            chk($sformatf("row%0d rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("row%0d wb_err", i), 32'(wb_err), 32'(vecs[i].e_err));
        end

        // Random phase: DUT is in its post-reset state here; model starts there too
        for (int k = 0; k < 8; k++) m_busy[k] = 1'b0;
        m_alu_pri = 1'b1; m_we = 1'b0; m_waddr = 0; m_wdata = 32'h0; m_err = 1'b0;

        for (int cyc = 0; cyc < 500; cyc++) begin
            bit eff[8];
            bit nb[8];
            bit e_stall, ga, gl;
            logic [7:0] pb;
            int wr;
            @(negedge clk);
            rst       = (cyc == 0) || ($urandom_range(0, 59) == 0);
            iss_valid = $urandom_range(0, 1) == 1;
            iss_rd_we = $urandom_range(0, 1) == 1;
            iss_rd    = 3'($urandom_range(0, 7));
            iss_rs1   = 3'($urandom_range(0, 7));
            iss_rs2   = 3'($urandom_range(0, 7));
            alu_valid = $urandom_range(0, 9) < 4;
            alu_rd    = 3'($urandom_range(0, 7));
            alu_data  = $urandom;
            lsu_valid = $urandom_range(0, 9) < 4;
            lsu_rd    = 3'($urandom_range(0, 7));
            lsu_data  = $urandom;
            #1;
            for (int k = 0; k < 8; k++) eff[k] = m_busy[k];
`ifdef WB_BYPASS_EN
            if (m_we) eff[m_waddr] = 1'b0;
`endif
            e_stall = iss_valid && (eff[iss_rs1] || eff[iss_rs2] || (iss_rd_we && eff[iss_rd]));
            ga = !rst && alu_valid && (!lsu_valid || m_alu_pri);
            gl = !rst && lsu_valid && (!alu_valid || !m_alu_pri);
            for (int k = 0; k < 8; k++) pb[k] = m_busy[k];

            chk("rand iss_stall", 32'(iss_stall), 32'(e_stall));
            chk("rand alu_ready", 32'(alu_ready), 32'(ga));
            chk("rand lsu_ready", 32'(lsu_ready), 32'(gl));
            chk("rand rf_we", 32'(rf_we), 32'(m_we));
            chk("rand rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            chk("rand rf_wdata", rf_wdata, m_wdata);
            chk("rand busy", 32'(busy), 32'(pb));
            chk("rand wb_err", 32'(wb_err), 32'(m_err));

            if (rst) begin
                for (int k = 0; k < 8; k++) m_busy[k] = 1'b0;
                m_alu_pri = 1'b1; m_we = 1'b0; m_waddr = 0; m_wdata = 32'h0; m_err = 1'b0;
            end else begin
                for (int k = 0; k < 8; k++) nb[k] = m_busy[k];
                if (m_we) nb[m_waddr] = 1'b0;
                if (iss_valid && !e_stall && iss_rd_we) nb[iss_rd] = 1'b1;
                if (ga || gl) begin
                    wr = ga ? int'(alu_rd) : int'(lsu_rd);
                    if (!m_busy[wr]) m_err = 1'b1;
                    m_we = 1'b1;
                    m_waddr = wr;
                    m_wdata = ga ? alu_data : lsu_data;
                    m_alu_pri = gl;
                end else begin
                    m_we = 1'b0;
                end
                for (int k = 0; k < 8; k++) m_busy[k] = nb[k];
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
